lit_row: RTL and testbench

- Parametrised literal row: stores the literal polarities of one clause segment of NUM_LITS literals.
- On request, evaluates the segment against current variable values and returns:
  - saturating free-literal count
  - clause-satisfied flag
  - conflict flag
  - a unit implication
  - conflict-analysis literal values
- Rows cascade through freelitcnt/clausesat chain ports to form wide clauses.
- Sits between the variable base and the clause bin controller; evaluation runs through a valid/ready handshake.

---
 rtl/lit_pkg.sv | 31 +++
 rtl/lit_eval_cell.sv | 24 ++
 rtl/lit_row.sv | 196 +++++++++++++++++++
 tb/tb_lit_row.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lit_pkg.sv
// Shared encodings, widths, FSM state type and the saturating free-count adder
// used by the literal row and its per-literal evaluation cells.
package lit_pkg;

    localparam int POL_W = 2;
    localparam int VAL_W = 3;

    localparam logic [1:0] POL_NONE = 2'b00;
    localparam logic [1:0] POL_POS  = 2'b01;
    localparam logic [1:0] POL_NEG  = 2'b10;

    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_TRUE  = 2'b01;
    localparam logic [1:0] VAL_FALSE = 2'b10;

    localparam logic [1:0] FREE_SAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HOLD
    } state_e;

    // Free counts only need to distinguish 0, 1 and "two or more"; code 3 means 2.
    function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, (a == 2'd3) ? FREE_SAT : a} + {1'b0, (b == 2'd3) ? FREE_SAT : b};
        return (sum >= 3'd2) ? FREE_SAT : sum[1:0];
    endfunction

endpackage

// File: rtl/lit_eval_cell.sv
// Combinational decode of one literal: presence, true/free/false classification
// and the value it would be forced to if it became the implied literal.
module lit_eval_cell
    import lit_pkg::*;
(
    input  logic [POL_W-1:0] pol_i,
    input  logic [1:0]       val_i,
    output logic             present_o,
    output logic             true_o,
    output logic             free_o,
    output logic             false_o,
    output logic [VAL_W-1:0] imp_val_o
);

    always_comb begin
        present_o = (pol_i != POL_NONE) && (pol_i != 2'b11);
        free_o    = present_o && ((val_i == VAL_FREE) || (val_i == 2'b11));
        true_o    = present_o && (((pol_i == POL_POS) && (val_i == VAL_TRUE)) ||
                                  ((pol_i == POL_NEG) && (val_i == VAL_FALSE)));
        false_o   = present_o && !free_o && !true_o;
        imp_val_o = {1'b1, (pol_i == POL_POS) ? VAL_TRUE : VAL_FALSE};
    end

endmodule

// File: rtl/lit_row.sv
// One clause segment of NUM_LITS literals: polarity store, evaluation FSM and the
// registered free-count / satisfied / conflict / implication results.
module lit_row
    import lit_pkg::*;
#(
    parameter int NUM_LITS = 8,
    parameter int IDX_W    = $clog2(NUM_LITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_i,
    input  logic [NUM_LITS*POL_W-1:0] lit_pol_i,
    output logic                      wr_drop_o,
    input  logic                      eval_valid_i,
    output logic                      eval_ready_o,
    input  logic [NUM_LITS*VAL_W-1:0] var_value_frombase_i,
    input  logic [1:0]                freelitcnt_pre,
    input  logic                      clausesat_pre_i,
    input  logic                      imp_drv_i,
    input  logic                      cclause_drv_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [1:0]                freelitcnt_next,
    output logic                      clausesat_o,
    output logic                      cclause_o,
    output logic                      imp_valid_o,
    output logic [IDX_W-1:0]          imp_idx_o,
    output logic [NUM_LITS*VAL_W-1:0] var_value_tobase_o
);

    state_e                      state_q, state_d;
    logic [NUM_LITS*POL_W-1:0]   pol_q, pol_d;
    logic [NUM_LITS*VAL_W-1:0]   val_q, val_d;
    logic [1:0]                  pre_q, pre_d;
    logic                        sat_pre_q, sat_pre_d;
    logic                        imp_drv_q, imp_drv_d;
    logic                        cc_drv_q, cc_drv_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        sat_q, sat_d;
    logic                        cc_q, cc_d;
    logic                        imp_valid_q, imp_valid_d;
    logic [IDX_W-1:0]            imp_idx_q, imp_idx_d;
    logic [NUM_LITS*VAL_W-1:0]   tobase_q, tobase_d;
    logic                        wr_drop_q, wr_drop_d;

    logic [NUM_LITS-1:0]         lit_present, lit_true, lit_free, lit_false;
    logic [VAL_W-1:0]            lit_imp_val [NUM_LITS];

    logic [1:0]                  local_cnt;
    logic [1:0]                  seg_cnt;
    logic                        seg_sat, seg_cc, seg_imp;
    logic [IDX_W-1:0]            free_idx;
    logic [NUM_LITS*VAL_W-1:0]   seg_tobase;

    for (genvar k = 0; k < NUM_LITS; k++) begin : g_cell
        lit_eval_cell u_cell (
            .pol_i     (pol_q[k*POL_W +: POL_W]),
            .val_i     (val_q[k*VAL_W +: 2]),
            .present_o (lit_present[k]),
            .true_o    (lit_true[k]),
            .free_o    (lit_free[k]),
            .false_o   (lit_false[k]),
            .imp_val_o (lit_imp_val[k])
        );

        a_lit_class: assert property (@(posedge clk) disable iff (!rst)
            $onehot0({lit_true[k], lit_free[k], lit_false[k]}) &&
            (lit_present[k] == (lit_true[k] | lit_free[k] | lit_false[k])));
    end

    // Segment evaluation over the captured operands; only latched at the end of CALC.
    always_comb begin
        local_cnt  = '0;
        free_idx   = '0;
        seg_tobase = '0;
        for (int k = NUM_LITS - 1; k >= 0; k--) begin
            if (lit_free[k]) begin
                free_idx = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_LITS; k++) begin
            if (lit_free[k] && (local_cnt != FREE_SAT)) begin
                local_cnt = local_cnt + 2'd1;
            end
        end
        seg_cnt = sat_add2(local_cnt, pre_q);
        seg_sat = sat_pre_q | (|lit_true);
        seg_cc  = !seg_sat && (seg_cnt == 2'd0);
        seg_imp = imp_drv_q && !seg_sat && (seg_cnt == 2'd1) && (local_cnt == 2'd1);
        if (seg_imp) begin
            seg_tobase[free_idx*VAL_W +: VAL_W] = lit_imp_val[free_idx];
        end else if (seg_cc && cc_drv_q) begin
            for (int k = 0; k < NUM_LITS; k++) begin
                if (lit_present[k]) begin
                    seg_tobase[k*VAL_W +: VAL_W] = val_q[k*VAL_W +: VAL_W];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pol_d       = pol_q;
        val_d       = val_q;
        pre_d       = pre_q;
        sat_pre_d   = sat_pre_q;
        imp_drv_d   = imp_drv_q;
        cc_drv_d    = cc_drv_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        cc_d        = cc_q;
        imp_valid_d = imp_valid_q;
        imp_idx_d   = imp_idx_q;
        tobase_d    = tobase_q;
        wr_drop_d   = wr_drop_q | (wr_i && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                // A same-cycle write lands in pol_q before CALC reads it.
                if (wr_i) begin
                    pol_d = lit_pol_i;
                end
                if (eval_valid_i) begin
                    state_d   = ST_CALC;
                    val_d     = var_value_frombase_i;
                    pre_d     = freelitcnt_pre;
                    sat_pre_d = clausesat_pre_i;
                    imp_drv_d = imp_drv_i;
                    cc_drv_d  = cclause_drv_i;
                end
            end
            ST_CALC: begin
                state_d     = ST_HOLD;
                cnt_d       = seg_cnt;
                sat_d       = seg_sat;
                cc_d        = seg_cc;
                imp_valid_d = seg_imp;
                imp_idx_d   = seg_imp ? free_idx : '0;
                tobase_d    = seg_tobase;
            end
            ST_HOLD: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pol_q       <= '0;
            val_q       <= '0;
            pre_q       <= '0;
            sat_pre_q   <= 1'b0;
            imp_drv_q   <= 1'b0;
            cc_drv_q    <= 1'b0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            cc_q        <= 1'b0;
            imp_valid_q <= 1'b0;
            imp_idx_q   <= '0;
            tobase_q    <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pol_q       <= pol_d;
            val_q       <= val_d;
            pre_q       <= pre_d;
            sat_pre_q   <= sat_pre_d;
            imp_drv_q   <= imp_drv_d;
            cc_drv_q    <= cc_drv_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            cc_q        <= cc_d;
            imp_valid_q <= imp_valid_d;
            imp_idx_q   <= imp_idx_d;
            tobase_q    <= tobase_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    a_imp_cc_excl: assert property (@(posedge clk) disable iff (!rst)
        !(imp_valid_q && cc_q));

    assign eval_ready_o       = (state_q == ST_IDLE);
    assign res_valid_o        = (state_q == ST_HOLD);
    assign freelitcnt_next    = cnt_q;
    assign clausesat_o        = sat_q;
    assign cclause_o          = cc_q;
    assign imp_valid_o        = imp_valid_q;
    assign imp_idx_o          = imp_idx_q;
    assign var_value_tobase_o = tobase_q;
    assign wr_drop_o          = wr_drop_q;

endmodule

// File: tb/tb_lit_row.sv
// Randomised and directed scoreboard bench for lit_row: a driver pushes
// reference-model results, a separate monitor pops and compares them.
module tb_lit_row;

    localparam int NL = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_i;
    logic [NL*2-1:0] lit_pol_i;
    logic            wr_drop_o;
    logic            eval_valid_i;
    logic            eval_ready_o;
    logic [NL*3-1:0] var_value_frombase_i;
    logic [1:0]      freelitcnt_pre;
    logic            clausesat_pre_i;
    logic            imp_drv_i;
    logic            cclause_drv_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [1:0]      freelitcnt_next;
    logic            clausesat_o;
    logic            cclause_o;
    logic            imp_valid_o;
    logic [IW-1:0]   imp_idx_o;
    logic [NL*3-1:0] var_value_tobase_o;

    lit_row #(.NUM_LITS(NL)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_i                 (wr_i),
        .lit_pol_i            (lit_pol_i),
        .wr_drop_o            (wr_drop_o),
        .eval_valid_i         (eval_valid_i),
        .eval_ready_o         (eval_ready_o),
        .var_value_frombase_i (var_value_frombase_i),
        .freelitcnt_pre       (freelitcnt_pre),
        .clausesat_pre_i      (clausesat_pre_i),
        .imp_drv_i            (imp_drv_i),
        .cclause_drv_i        (cclause_drv_i),
        .res_valid_o          (res_valid_o),
        .res_ready_i          (res_ready_i),
        .freelitcnt_next      (freelitcnt_next),
        .clausesat_o          (clausesat_o),
        .cclause_o            (cclause_o),
        .imp_valid_o          (imp_valid_o),
        .imp_idx_o            (imp_idx_o),
        .var_value_tobase_o   (var_value_tobase_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      cnt;
        logic            sat;
        logic            cc;
        logic            imp;
        logic [IW-1:0]   idx;
        logic [NL*3-1:0] tb;
    } res_t;

    res_t        exp_q[$];
    res_t        cur_exp;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] model_pol;
    logic        model_drop;
    bit          mon_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Clause rules applied literally: count free present lits, any true one satisfies.
    function automatic res_t refModel(input logic [15:0] pol, input logic [23:0] vals,
                                      input logic [1:0] pre, input logic satpre,
                                      input logic impdrv, input logic ccdrv);
        int          nfree = 0;
        int          first = -1;
        int          total;
        logic        any_true = 1'b0;
        logic [1:0]  p;
        logic [2:0]  v;
        res_t        r;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            p = pol[2*k +: 2];
            v = vals[3*k +: 3];
            if (p == 2'b01 || p == 2'b10) begin
                if (v[1:0] == 2'b00 || v[1:0] == 2'b11) begin
                    nfree++;
                    if (first < 0) first = k;
                end else if ((p == 2'b01 && v[1:0] == 2'b01) || (p == 2'b10 && v[1:0] == 2'b10)) begin
                    any_true = 1'b1;
                end
            end
        end
        total = nfree + ((pre == 2'd3) ? 2 : int'(pre));
        if (total > 2) total = 2;
        r.cnt = 2'(total);
        r.sat = satpre | any_true;
        r.cc  = !r.sat && (total == 0);
        r.imp = impdrv && !r.sat && (total == 1) && (nfree == 1);
        if (r.imp) begin
            r.idx = IW'(first);
            r.tb[3*first +: 3] = (pol[2*first +: 2] == 2'b01) ? 3'b101 : 3'b110;
        end else if (r.cc && ccdrv) begin
            for (int k = 0; k < NL; k++) begin
                if (pol[2*k +: 2] == 2'b01 || pol[2*k +: 2] == 2'b10) r.tb[3*k +: 3] = vals[3*k +: 3];
            end
        end
        return r;
    endfunction

    function automatic res_t dutResult();
        return {freelitcnt_next, clausesat_o, cclause_o, imp_valid_o, imp_idx_o, var_value_tobase_o};
    endfunction

    task automatic waitReady();
        int waited = 0;
        @(negedge clk);
        while (!eval_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_timeout", eval_ready_o, 1);
    endtask

    task automatic issue(input logic do_wr, input logic [15:0] pol, input logic [23:0] vals,
                         input logic [1:0] pre, input logic satpre, input logic impdrv, input logic ccdrv);
        wr_i                 = do_wr;
        lit_pol_i            = pol;
        eval_valid_i         = 1'b1;
        var_value_frombase_i = vals;
        freelitcnt_pre       = pre;
        clausesat_pre_i      = satpre;
        imp_drv_i            = impdrv;
        cclause_drv_i        = ccdrv;
        if (do_wr) model_pol = pol;
        exp_q.push_back(refModel(model_pol, vals, pre, satpre, impdrv, ccdrv));
        @(posedge clk);
        #1;
        checkOutput("calc_not_ready", eval_ready_o, 0);
        checkOutput("calc_no_valid", res_valid_o, 0);
        @(negedge clk);
        eval_valid_i         = 1'b0;
        wr_i                 = 1'b0;
        var_value_frombase_i = 24'($urandom);
        freelitcnt_pre       = 2'($urandom);
        clausesat_pre_i      = 1'($urandom);
        imp_drv_i            = 1'($urandom);
        cclause_drv_i        = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic do_wr, input logic [15:0] pol, input logic [23:0] vals,
                                 input logic [1:0] pre, input logic satpre, input logic impdrv,
                                 input logic ccdrv, input logic wr_calc, input int hold);
        waitReady();
        issue(do_wr, pol, vals, pre, satpre, impdrv, ccdrv);
        if (wr_calc) begin
            wr_i       = 1'b1;
            lit_pol_i  = 16'($urandom);
            model_drop = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_i = 1'b0;
        checkOutput("latency", res_valid_o, 1);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        res_ready_i = 1'b0;
        checkOutput("ready_back", eval_ready_o, 1);
        checkOutput("valid_drop", res_valid_o, 0);
        checkOutput("wr_drop", wr_drop_o, model_drop);
    endtask

    task automatic resetInHold();
        waitReady();
        issue(1'b0, 16'($urandom), 24'($urandom), 2'd0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_valid_low", res_valid_o, 0);
        checkOutput("rst_ready_high", eval_ready_o, 1);
        checkOutput("rst_drop_clear", wr_drop_o, 0);
        checkOutput("rst_outputs", dutResult(), '0);
        model_pol  = '0;
        model_drop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_ready", eval_ready_o, 1);
    endtask

    // Monitor: a rising res_valid_o presents a new result; later HOLD cycles must not change it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && res_valid_o === 1'b1) begin
                if (!mon_prev) begin
                    checkOutput("result_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur_exp = exp_q.pop_front();
                        checkOutput("result", dutResult(), cur_exp);
                    end
                end else begin
                    checkOutput("hold_stable", dutResult(), cur_exp);
                end
                checkOutput("hold_not_ready", eval_ready_o, 0);
                mon_prev = 1'b1;
            end else begin
                mon_prev = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rpol;
        logic [23:0] rval;
        rst = 1'b0;
        wr_i = 1'b0;
        lit_pol_i = '0;
        eval_valid_i = 1'b0;
        var_value_frombase_i = '0;
        freelitcnt_pre = '0;
        clausesat_pre_i = 1'b0;
        imp_drv_i = 1'b0;
        cclause_drv_i = 1'b0;
        res_ready_i = 1'b0;
        model_pol = '0;
        model_drop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", eval_ready_o, 1);
        checkOutput("reset_valid", res_valid_o, 0);
        checkOutput("reset_drop", wr_drop_o, 0);
        checkOutput("reset_outputs", dutResult(), '0);
        rst = 1'b1;

        applyStimulus(1'b0, 16'h0000, 24'h000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 16'h0009, 24'h000012, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 16'hFFFF, 24'h000002, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 24'h000002, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 24'h000000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 16'hFFFF, 24'h00000A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 24'h00000A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 24'h000002, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 16'hFFFF, 24'h000002, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 16'h0006, 24'h000010, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        resetInHold();
        applyStimulus(1'b0, 16'hFFFF, 24'h000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            rpol = '0;
            rval = '0;
            for (int k = 0; k < NL; k++) begin
                rpol[2*k +: 2] = 2'($urandom_range(0, 3));
                rval[3*k +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
                                 {1'b0, 2'($urandom_range(1, 2))};
            end
            applyStimulus(1'($urandom_range(0, 2) == 0), rpol, rval, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 15) == 0), $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
